// File: rtl/trap_ctrl_if.sv
// Retiring-instruction / CSR-update bundle between the pipeline and the trap controller.
// The slave modport is the trap controller's view.
interface trap_ctrl_if;
  localparam int unsigned XLEN = 32;

  logic            valid_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] inst_i;
  logic [XLEN-1:0] badaddr_i;
  logic            e_inst_misalign_i;
  logic            e_illegal_i;
  logic            e_ebreak_i;
  logic            e_ecall_i;
  logic            e_ld_misalign_i;
  logic            e_st_misalign_i;
  logic            is_mret_i;
  logic [XLEN-1:0] mstatus_i;
  logic [XLEN-1:0] mie_i;
  logic [XLEN-1:0] mepc_i;
  logic [XLEN-1:0] mcause_i;
  logic [XLEN-1:0] mtval_i;
  logic            ext_irq_i;
  logic            timer_irq_i;
  logic            sw_irq_i;

  logic            we_exc_o;
  logic            is_int_o;
  logic [XLEN-1:0] mcause_d_o;
  logic [XLEN-1:0] mepc_d_o;
  logic [XLEN-1:0] mtval_d_o;
  logic [XLEN-1:0] mstatus_d_o;
  logic [XLEN-1:0] mip_d_o;
  logic            sel_exc_nret_o;
  logic            stall_o;
  logic            flush_o;
  logic            redirect_o;

  modport slave (
    input  valid_i, pc_i, inst_i, badaddr_i,
           e_inst_misalign_i, e_illegal_i, e_ebreak_i, e_ecall_i,
           e_ld_misalign_i, e_st_misalign_i, is_mret_i,
           mstatus_i, mie_i, mepc_i, mcause_i, mtval_i,
           ext_irq_i, timer_irq_i, sw_irq_i,
    output we_exc_o, is_int_o, mcause_d_o, mepc_d_o, mtval_d_o,
           mstatus_d_o, mip_d_o, sel_exc_nret_o, stall_o, flush_o, redirect_o
  );

  modport master (
    output valid_i, pc_i, inst_i, badaddr_i,
           e_inst_misalign_i, e_illegal_i, e_ebreak_i, e_ecall_i,
           e_ld_misalign_i, e_st_misalign_i, is_mret_i,
           mstatus_i, mie_i, mepc_i, mcause_i, mtval_i,
           ext_irq_i, timer_irq_i, sw_irq_i,
    input  we_exc_o, is_int_o, mcause_d_o, mepc_d_o, mtval_d_o,
           mstatus_d_o, mip_d_o, sel_exc_nret_o, stall_o, flush_o, redirect_o
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: prioritises exceptions / MRET / interrupts of the retiring
// instruction, then stalls, commits the CSR update bundle and redirects fetch.
module trap_ctrl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic        clk_i,
  input logic        rst_i,
  trap_ctrl_if.slave bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NIRQ  = 3;
  localparam int unsigned NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [XLEN-1:0] INT_FLAG            = XLEN'(32'h8000_0000);
  localparam logic [XLEN-1:0] CAUSE_INST_MISALIGN = XLEN'(0);
  localparam logic [XLEN-1:0] CAUSE_ILLEGAL       = XLEN'(2);
  localparam logic [XLEN-1:0] CAUSE_EBREAK        = XLEN'(3);
  localparam logic [XLEN-1:0] CAUSE_LD_MISALIGN   = XLEN'(4);
  localparam logic [XLEN-1:0] CAUSE_ST_MISALIGN   = XLEN'(6);
  localparam logic [XLEN-1:0] CAUSE_ECALL         = XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_MSI           = XLEN'(3);
  localparam logic [XLEN-1:0] CAUSE_MTI           = XLEN'(7);
  localparam logic [XLEN-1:0] CAUSE_MEI           = XLEN'(11);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COMMIT   = 2'd1,
    S_REDIRECT = 2'd2
  } state_e;

  state_e state_q, state_d;

  // irq synchronizer stages, each {ext, timer, sw}
  logic [NIRQ-1:0] sync_q [NSYNC];
  logic [NIRQ-1:0] sync_d [NSYNC];

  logic [NIRQ-1:0] irq_c;
  logic [XLEN-1:0] mip_c;
  logic [XLEN-1:0] irq_en_c;
  logic            exc_any_c;
  logic            irq_pend_c;
  logic            event_c;
  logic [XLEN-1:0] cause_c;
  logic [XLEN-1:0] epc_c;
  logic [XLEN-1:0] tval_c;
  logic [XLEN-1:0] status_c;
  logic            sel_c;
  logic            int_c;

  logic [XLEN-1:0] mcause_q,  mcause_d;
  logic [XLEN-1:0] mepc_q,    mepc_d;
  logic [XLEN-1:0] mtval_q,   mtval_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic            sel_q,      sel_d;
  logic            is_int_q,   is_int_d;
  logic            we_exc_q,   we_exc_d;
  logic            stall_q,    stall_d;
  logic            flush_q,    flush_d;
  logic            redirect_q, redirect_d;

  always_comb begin
    sync_d[0] = {bus.ext_irq_i, bus.timer_irq_i, bus.sw_irq_i};
    for (int i = 1; i < int'(NSYNC); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // mip image of the synchronized lines: MEIP=11, MTIP=7, MSIP=3
  always_comb begin
    irq_c     = sync_q[NSYNC-1];
    mip_c     = '0;
    mip_c[11] = irq_c[2];
    mip_c[7]  = irq_c[1];
    mip_c[3]  = irq_c[0];
  end

  // Event classification and CSR data for the retiring instruction
  always_comb begin
    irq_en_c   = mip_c & bus.mie_i;
    exc_any_c  = bus.e_inst_misalign_i | bus.e_illegal_i | bus.e_ebreak_i |
                 bus.e_ecall_i | bus.e_ld_misalign_i | bus.e_st_misalign_i;
    irq_pend_c = bus.mstatus_i[3] && (|irq_en_c);
    event_c    = bus.valid_i && (exc_any_c || bus.is_mret_i || irq_pend_c);

    cause_c  = '0;
    epc_c    = bus.pc_i;
    tval_c   = '0;
    status_c = bus.mstatus_i;
    sel_c    = 1'b0;
    int_c    = 1'b0;

    if (exc_any_c) begin
      status_c[7]     = bus.mstatus_i[3];
      status_c[3]     = 1'b0;
      status_c[12:11] = 2'b11;
      if (bus.e_inst_misalign_i) begin
        cause_c = CAUSE_INST_MISALIGN;
        tval_c  = bus.badaddr_i;
      end else if (bus.e_illegal_i) begin
        cause_c = CAUSE_ILLEGAL;
        tval_c  = bus.inst_i;
      end else if (bus.e_ebreak_i) begin
        cause_c = CAUSE_EBREAK;
        tval_c  = bus.pc_i;
      end else if (bus.e_ecall_i) begin
        cause_c = CAUSE_ECALL;
      end else if (bus.e_ld_misalign_i) begin
        cause_c = CAUSE_LD_MISALIGN;
        tval_c  = bus.badaddr_i;
      end else begin
        cause_c = CAUSE_ST_MISALIGN;
        tval_c  = bus.badaddr_i;
      end
    end else if (bus.is_mret_i) begin
      cause_c         = bus.mcause_i;
      epc_c           = bus.mepc_i;
      tval_c          = bus.mtval_i;
      status_c[3]     = bus.mstatus_i[7];
      status_c[7]     = 1'b1;
      status_c[12:11] = 2'b11;
      sel_c           = 1'b1;
    end else begin
      int_c           = 1'b1;
      status_c[7]     = bus.mstatus_i[3];
      status_c[3]     = 1'b0;
      status_c[12:11] = 2'b11;
      if (irq_en_c[11]) begin
        cause_c = INT_FLAG | CAUSE_MEI;
      end else if (irq_en_c[3]) begin
        cause_c = INT_FLAG | CAUSE_MSI;
      end else begin
        cause_c = INT_FLAG | CAUSE_MTI;
      end
    end
  end

  // Next state, latched CSR bundle and registered strobes
  always_comb begin
    state_d   = state_q;
    mcause_d  = mcause_q;
    mepc_d    = mepc_q;
    mtval_d   = mtval_q;
    mstatus_d = mstatus_q;
    sel_d     = sel_q;
    is_int_d  = 1'b0;
    we_exc_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (event_c) begin
          state_d   = S_COMMIT;
          mcause_d  = cause_c;
          mepc_d    = epc_c;
          mtval_d   = tval_c;
          mstatus_d = status_c;
          sel_d     = sel_c;
          is_int_d  = int_c;
          we_exc_d  = 1'b1;
        end
      end
      S_COMMIT: begin
        state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        state_d   = S_IDLE;
        mcause_d  = '0;
        mepc_d    = '0;
        mtval_d   = '0;
        mstatus_d = '0;
        sel_d     = 1'b0;
      end
      default: begin
        state_d   = S_IDLE;
        mcause_d  = '0;
        mepc_d    = '0;
        mtval_d   = '0;
        mstatus_d = '0;
        sel_d     = 1'b0;
      end
    endcase

    redirect_d = (state_d == S_REDIRECT);
    flush_d    = (state_d == S_REDIRECT);
    stall_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < int'(NSYNC); i++) begin
        sync_q[i] <= '0;
      end
      mcause_q   <= '0;
      mepc_q     <= '0;
      mtval_q    <= '0;
      mstatus_q  <= '0;
      sel_q      <= 1'b0;
      is_int_q   <= 1'b0;
      we_exc_q   <= 1'b0;
      stall_q    <= 1'b0;
      flush_q    <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      for (int i = 0; i < int'(NSYNC); i++) begin
        sync_q[i] <= sync_d[i];
      end
      mcause_q   <= mcause_d;
      mepc_q     <= mepc_d;
      mtval_q    <= mtval_d;
      mstatus_q  <= mstatus_d;
      sel_q      <= sel_d;
      is_int_q   <= is_int_d;
      we_exc_q   <= we_exc_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
    end
  end

  assign bus.we_exc_o       = we_exc_q;
  assign bus.is_int_o       = is_int_q;
  assign bus.mcause_d_o     = mcause_q;
  assign bus.mepc_d_o       = mepc_q;
  assign bus.mtval_d_o      = mtval_q;
  assign bus.mstatus_d_o    = mstatus_q;
  assign bus.mip_d_o        = mip_c;
  assign bus.sel_exc_nret_o = sel_q;
  assign bus.stall_o        = stall_q;
  assign bus.flush_o        = flush_q;
  assign bus.redirect_o     = redirect_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed cases plus randomized retiring instructions
// checked against a rule-level reference model.
module tb_trap_ctrl;

  localparam int unsigned SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  trap_ctrl_if bus ();

  trap_ctrl #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit irq_e = 1'b0;
  bit irq_t = 1'b0;
  bit irq_s = 1'b0;

  typedef struct {
    bit          taken;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] tval;
    logic [31:0] status;
    bit          sel;
    bit          is_int;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_mip();
    return (32'(irq_e) << 11) | (32'(irq_t) << 7) | (32'(irq_s) << 3);
  endfunction

  // Reference model: decides the outcome from the current (settled) inputs
  function automatic exp_t model();
    exp_t        r;
    bit          exc [6];
    int          code [6];
    int          irq_order [3];
    logic [31:0] m;
    logic [31:0] en;
    int          hit;
    exc       = '{bus.e_inst_misalign_i, bus.e_illegal_i, bus.e_ebreak_i,
                  bus.e_ecall_i, bus.e_ld_misalign_i, bus.e_st_misalign_i};
    code      = '{0, 2, 3, 11, 4, 6};
    irq_order = '{11, 3, 7};
    m         = bus.mstatus_i;
    en        = exp_mip() & bus.mie_i;
    r         = '{taken: 1'b0, cause: 32'h0, epc: 32'h0, tval: 32'h0,
                  status: 32'h0, sel: 1'b0, is_int: 1'b0};
    hit = -1;
    for (int i = 0; i < 6; i++) begin
      if (exc[i] && hit < 0) hit = code[i];
    end
    if (!bus.valid_i) return r;
    if (hit >= 0) begin
      r.taken  = 1'b1;
      r.cause  = 32'(hit);
      r.epc    = bus.pc_i;
      r.status = (m & ~32'h1888) | 32'h1800 | (32'(m[3]) << 7);
      case (hit)
        2:       r.tval = bus.inst_i;
        3:       r.tval = bus.pc_i;
        11:      r.tval = 32'h0;
        default: r.tval = bus.badaddr_i;
      endcase
    end else if (bus.is_mret_i) begin
      r.taken  = 1'b1;
      r.cause  = bus.mcause_i;
      r.epc    = bus.mepc_i;
      r.tval   = bus.mtval_i;
      r.status = (m & ~32'h1888) | 32'h1880 | (32'(m[7]) << 3);
      r.sel    = 1'b1;
    end else if (m[3] && en != 32'h0) begin
      r.taken  = 1'b1;
      r.is_int = 1'b1;
      r.epc    = bus.pc_i;
      r.tval   = 32'h0;
      r.status = (m & ~32'h1888) | 32'h1800 | (32'(m[3]) << 7);
      for (int i = 2; i >= 0; i--) begin
        if (en[irq_order[i]]) r.cause = 32'h8000_0000 | 32'(irq_order[i]);
      end
    end
    return r;
  endfunction

  task automatic idle_inputs();
    bus.valid_i           = 1'b0;
    bus.e_inst_misalign_i = 1'b0;
    bus.e_illegal_i       = 1'b0;
    bus.e_ebreak_i        = 1'b0;
    bus.e_ecall_i         = 1'b0;
    bus.e_ld_misalign_i   = 1'b0;
    bus.e_st_misalign_i   = 1'b0;
    bus.is_mret_i         = 1'b0;
  endtask

  task automatic rand_inputs();
    bus.valid_i           = ($urandom_range(0, 3) != 0);
    bus.e_inst_misalign_i = ($urandom_range(0, 9) == 0);
    bus.e_illegal_i       = ($urandom_range(0, 9) == 0);
    bus.e_ebreak_i        = ($urandom_range(0, 9) == 0);
    bus.e_ecall_i         = ($urandom_range(0, 9) == 0);
    bus.e_ld_misalign_i   = ($urandom_range(0, 9) == 0);
    bus.e_st_misalign_i   = ($urandom_range(0, 9) == 0);
    bus.is_mret_i         = ($urandom_range(0, 5) == 0);
    bus.pc_i              = $urandom & 32'hFFFF_FFFC;
    bus.inst_i            = $urandom;
    bus.badaddr_i         = $urandom;
    bus.mstatus_i         = $urandom;
    bus.mie_i             = $urandom;
    bus.mepc_i            = $urandom;
    bus.mcause_i          = $urandom;
    bus.mtval_i           = $urandom;
  endtask

  // Change the irq lines and give them time to cross the synchronizer
  task automatic set_irq(input bit e, input bit t, input bit s);
    irq_e = e; irq_t = t; irq_s = s;
    bus.ext_irq_i   = e;
    bus.timer_irq_i = t;
    bus.sw_irq_i    = s;
    idle_inputs();
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1;
  endtask

  // hold: 0 = quiet during stall, 1 = random traffic, 2 = a second ecall
  task automatic run_txn(input string tag, input int hold);
    exp_t e;
    e = model();
    @(posedge clk); #1;
    if (e.taken) begin
      check({tag, ".c.we_exc"},  32'(bus.we_exc_o),       32'h1);
      check({tag, ".c.is_int"},  32'(bus.is_int_o),       32'(e.is_int));
      check({tag, ".c.stall"},   32'(bus.stall_o),        32'h1);
      check({tag, ".c.redir"},   32'(bus.redirect_o),     32'h0);
      check({tag, ".c.mcause"},  bus.mcause_d_o,          e.cause);
      check({tag, ".c.mepc"},    bus.mepc_d_o,            e.epc);
      check({tag, ".c.mtval"},   bus.mtval_d_o,           e.tval);
      check({tag, ".c.mstatus"}, bus.mstatus_d_o,         e.status);
      check({tag, ".c.sel"},     32'(bus.sel_exc_nret_o), 32'(e.sel));
      check({tag, ".c.mip"},     bus.mip_d_o,             exp_mip());
      if (hold == 1) rand_inputs();
      else if (hold == 2) begin
        idle_inputs();
        bus.valid_i   = 1'b1;
        bus.e_ecall_i = 1'b1;
      end else idle_inputs();
      @(posedge clk); #1;
      check({tag, ".r.redir"},  32'(bus.redirect_o),     32'h1);
      check({tag, ".r.flush"},  32'(bus.flush_o),        32'h1);
      check({tag, ".r.stall"},  32'(bus.stall_o),        32'h1);
      check({tag, ".r.we_exc"}, 32'(bus.we_exc_o),       32'h0);
      check({tag, ".r.is_int"}, 32'(bus.is_int_o),       32'h0);
      check({tag, ".r.sel"},    32'(bus.sel_exc_nret_o), 32'(e.sel));
      check({tag, ".r.mcause"}, bus.mcause_d_o,          e.cause);
      idle_inputs();
      @(posedge clk); #1;
      check({tag, ".i.stall"},   32'(bus.stall_o),        32'h0);
      check({tag, ".i.we_exc"},  32'(bus.we_exc_o),       32'h0);
      check({tag, ".i.redir"},   32'(bus.redirect_o),     32'h0);
      check({tag, ".i.mcause"},  bus.mcause_d_o,          32'h0);
      check({tag, ".i.mstatus"}, bus.mstatus_d_o,         32'h0);
      check({tag, ".i.sel"},     32'(bus.sel_exc_nret_o), 32'h0);
    end else begin
      check({tag, ".n.we_exc"}, 32'(bus.we_exc_o),   32'h0);
      check({tag, ".n.stall"},  32'(bus.stall_o),    32'h0);
      check({tag, ".n.redir"},  32'(bus.redirect_o), 32'h0);
      check({tag, ".n.mcause"}, bus.mcause_d_o,      32'h0);
      check({tag, ".n.mip"},    bus.mip_d_o,         exp_mip());
      idle_inputs();
    end
  endtask

  initial begin
    idle_inputs();
    bus.pc_i = '0; bus.inst_i = '0; bus.badaddr_i = '0;
    bus.mstatus_i = '0; bus.mie_i = '0;
    bus.mepc_i = '0; bus.mcause_i = '0; bus.mtval_i = '0;
    bus.ext_irq_i = 1'b0; bus.timer_irq_i = 1'b0; bus.sw_irq_i = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.we_exc",  32'(bus.we_exc_o),       32'h0);
    check("rst.is_int",  32'(bus.is_int_o),       32'h0);
    check("rst.stall",   32'(bus.stall_o),        32'h0);
    check("rst.flush",   32'(bus.flush_o),        32'h0);
    check("rst.redir",   32'(bus.redirect_o),     32'h0);
    check("rst.mcause",  bus.mcause_d_o,          32'h0);
    check("rst.mstatus", bus.mstatus_d_o,         32'h0);
    check("rst.mip",     bus.mip_d_o,             32'h0);
    check("rst.sel",     32'(bus.sel_exc_nret_o), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ecall
    bus.valid_i = 1'b1; bus.e_ecall_i = 1'b1; bus.pc_i = 32'h100; bus.mstatus_i = 32'h8;
    run_txn("ecall", 0);

    // illegal beats ld_misalign
    bus.valid_i = 1'b1; bus.e_illegal_i = 1'b1; bus.e_ld_misalign_i = 1'b1;
    bus.inst_i = 32'hFFFF_FFFF; bus.badaddr_i = 32'h1234_5677; bus.pc_i = 32'h200;
    run_txn("illegal_ld", 0);

    // MRET
    bus.valid_i = 1'b1; bus.is_mret_i = 1'b1; bus.mstatus_i = 32'h1880;
    bus.mepc_i = 32'h104; bus.mcause_i = 32'hB; bus.mtval_i = 32'h0;
    run_txn("mret", 0);

    // timer interrupt, enabled then globally disabled
    set_irq(1'b0, 1'b1, 1'b0);
    bus.valid_i = 1'b1; bus.mie_i = 32'h80; bus.mstatus_i = 32'h8; bus.pc_i = 32'h300;
    run_txn("mti", 0);
    bus.valid_i = 1'b1; bus.mie_i = 32'h80; bus.mstatus_i = 32'h0;
    run_txn("mti_off", 0);

    // all three pending, second ecall during COMMIT must be ignored
    set_irq(1'b1, 1'b1, 1'b1);
    bus.valid_i = 1'b1; bus.mie_i = 32'h888; bus.mstatus_i = 32'h8; bus.pc_i = 32'h400;
    run_txn("all_irq", 2);

    // MSI beats MTI when MEI not enabled
    bus.valid_i = 1'b1; bus.mie_i = 32'h088; bus.mstatus_i = 32'h8;
    run_txn("msi_mti", 0);

    // reset during COMMIT
    set_irq(1'b0, 1'b0, 1'b0);
    bus.valid_i = 1'b1; bus.e_ecall_i = 1'b1; bus.pc_i = 32'h500; bus.mstatus_i = 32'h8;
    @(posedge clk); #1;
    check("rstc.commit", 32'(bus.we_exc_o), 32'h1);
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    check("rstc.we_exc",  32'(bus.we_exc_o),       32'h0);
    check("rstc.stall",   32'(bus.stall_o),        32'h0);
    check("rstc.redir",   32'(bus.redirect_o),     32'h0);
    check("rstc.flush",   32'(bus.flush_o),        32'h0);
    check("rstc.mcause",  bus.mcause_d_o,          32'h0);
    check("rstc.mepc",    bus.mepc_d_o,            32'h0);
    check("rstc.mstatus", bus.mstatus_d_o,         32'h0);
    check("rstc.sel",     32'(bus.sel_exc_nret_o), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rstc.redir2", 32'(bus.redirect_o), 32'h0);
    check("rstc.stall2", 32'(bus.stall_o),    32'h0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      if (n % 5 == 0) begin
        set_irq(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      rand_inputs();
      run_txn($sformatf("rnd%0d", n), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
